// File: rtl/adc_core_pkg.sv
// Shared constants, FSM state type and sample rebuild helper for the AD9263 capture path.
package adc_core_pkg;
    localparam logic [7:0] c_fco_pattern  = 8'hF0;
    localparam int         c_adc_bits     = 14;
    localparam int         c_num_channels = 4;
    localparam int         c_num_lanes    = 8;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} t_align_state;

    // Even lane carries d12..d0, odd lane d13..d1, earliest bit first; bit 0 is pad.
    function automatic logic [c_adc_bits-1:0] rebuild_sample(input logic [7:0] e, input logic [7:0] o);
        logic [c_adc_bits-1:0] s;
        for (int i = 0; i < 7; i++) begin
            s[2*i]   = e[i+1];
            s[2*i+1] = o[i+1];
        end
        return s;
    endfunction
endpackage

// File: rtl/ad9263_lane_window.sv
// Per-lane 16-bit word history and rotation mux; offset 0 returns the previous word unchanged.
module ad9263_lane_window (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word,
    input  logic [2:0] offset,
    output logic [7:0] win
);
    logic [15:0] hist;

    always_ff @(posedge clk) begin
        if (rst) hist <= '0;
        else     hist <= {hist[7:0], word};
    end

    assign win = hist[15 - offset -: 8];
endmodule

// File: rtl/ad9263_frame_aligner.sv
// Frame aligner: scans bit rotations for the FCO pattern, holds lock, and rebuilds 4 channels of samples.
module ad9263_frame_aligner
    import adc_core_pkg::*;
#(
    parameter int g_lock_count    = 16,
    parameter int g_unlock_errors = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic [7:0]  fco_word_i,
    input  logic [63:0] d_word_i,
    input  logic        align_restart_i,
    output logic [55:0] ch_data_o,
    output logic        valid_o,
    output logic        locked_o,
    output logic [2:0]  offset_o
);
    localparam int c_cnt_w = $clog2(g_lock_count + 1);
    localparam int c_err_w = $clog2(g_unlock_errors + 1);

    t_align_state                              state;
    logic [2:0]                                offset;
    logic [c_cnt_w-1:0]                        cnt;
    logic [c_err_w-1:0]                        err;
    logic [7:0]                                fco_win;
    logic [c_num_lanes-1:0][7:0]               d_win;
    logic [c_num_channels-1:0][c_adc_bits-1:0] samples;
    logic                                      match;

    ad9263_lane_window u_fco (
        .clk(clk_sys_i), .rst(rst_i), .word(fco_word_i), .offset(offset), .win(fco_win)
    );

    ad9263_lane_window u_lane [c_num_lanes-1:0] (
        .clk(clk_sys_i), .rst(rst_i), .word(d_word_i), .offset(offset), .win(d_win)
    );

    genvar c;
    generate
        for (c = 0; c < c_num_channels; c++) begin : g_ch
            assign samples[c] = rebuild_sample(d_win[2*c], d_win[2*c+1]);
        end
    endgenerate

    assign match    = (fco_win == c_fco_pattern);
    assign offset_o = offset;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state     <= SEARCH;
            offset    <= '0;
            cnt       <= '0;
            err       <= '0;
            ch_data_o <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (align_restart_i) begin
                state    <= SEARCH;
                offset   <= '0;
                cnt      <= '0;
                err      <= '0;
                locked_o <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (match) begin
                            state <= VERIFY;
                            cnt   <= c_cnt_w'(1);
                        end else begin
                            offset <= offset + 3'd1;
                        end
                    end
                    VERIFY: begin
                        if (!match) begin
                            state  <= SEARCH;
                            cnt    <= '0;
                            offset <= offset + 3'd1;
                        end else if (cnt == c_cnt_w'(g_lock_count - 1)) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            cnt      <= '0;
                            err      <= '0;
                        end else begin
                            cnt <= cnt + c_cnt_w'(1);
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            err       <= '0;
                            valid_o   <= 1'b1;
                            ch_data_o <= samples;
                        end else if (err == c_err_w'(g_unlock_errors - 1)) begin
                            state    <= SEARCH;
                            locked_o <= 1'b0;
                            err      <= '0;
                            offset   <= offset + 3'd1;
                        end else begin
                            err <= err + c_err_w'(1);
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
